// File: rtl/lm32_dtlb_assoc_if.sv
// Pipeline-side and TLB-maintenance signals of the set-associative data TLB,
// bundled so the pipeline (master) and the TLB (slave) connect through one port.
interface lm32_dtlb_assoc_if #(
   parameter int ASID_WIDTH = 8
);
   logic                  enable;
   logic                  stall_x;
   logic                  stall_m;
   logic [31:0]           address_x;
   logic [31:0]           address_m;
   logic                  load_d;
   logic                  store_d;
   logic                  load_q_x;
   logic                  store_q_x;
   logic [ASID_WIDTH-1:0] asid;
   logic [31:0]           tlbvaddr;
   logic [31:0]           tlbpaddr;
   logic [1:0]            tlbflags;
   logic                  update;
   logic                  invalidate;
   logic                  flush;
   logic                  flush_asid;
   logic [31:0]           physical_load_store_address_m;
   logic                  stall_request;
   logic                  miss;
   logic                  fault;

   modport master (
      output enable, stall_x, stall_m, address_x, address_m,
      output load_d, store_d, load_q_x, store_q_x, asid,
      output tlbvaddr, tlbpaddr, tlbflags, update, invalidate, flush, flush_asid,
      input  physical_load_store_address_m, stall_request, miss, fault
   );

   modport slave (
      input  enable, stall_x, stall_m, address_x, address_m,
      input  load_d, store_d, load_q_x, store_q_x, asid,
      input  tlbvaddr, tlbpaddr, tlbflags, update, invalidate, flush, flush_asid,
      output physical_load_store_address_m, stall_request, miss, fault
   );
endinterface

// File: rtl/lm32_dtlb_assoc.sv
// WAYS-way set-associative data TLB: registered X-stage lookup, per-set
// round-robin replacement, and a one-set-per-cycle full / per-ASID flush engine.
module lm32_dtlb_assoc #(
   parameter int ENTRIES    = 1024,
   parameter int WAYS       = 2,
   parameter int PAGE_SIZE  = 4096,
   parameter int ASID_WIDTH = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   lm32_dtlb_assoc_if.slave     bus
);
   localparam int OFFSET_W = $clog2(PAGE_SIZE);
   localparam int INDEX_W  = $clog2(ENTRIES);
   localparam int TAG_W    = 32 - OFFSET_W - INDEX_W;
   localparam int PFN_W    = 32 - OFFSET_W;
   localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam logic [INDEX_W-1:0] LAST_SET = INDEX_W'(ENTRIES - 1);

   typedef enum logic { CHECK, FLUSH }        state_t;
   typedef enum logic { MODE_ALL, MODE_ASID } mode_t;

   state_t                state_q, state_d;
   mode_t                 mode_q, mode_d;
   logic [INDEX_W-1:0]    flush_set_q, flush_set_d;
   logic [ASID_WIDTH-1:0] flush_asid_q, flush_asid_d;
   logic                  lookup_q;
   logic [PFN_W-1:0]      pfn_m_q;

   logic [INDEX_W-1:0] x_idx, c_idx;
   logic [TAG_W-1:0]   x_tag, c_tag;
   assign x_idx = bus.address_x[OFFSET_W+INDEX_W-1:OFFSET_W];
   assign x_tag = bus.address_x[31:OFFSET_W+INDEX_W];
   assign c_idx = bus.tlbvaddr[OFFSET_W+INDEX_W-1:OFFSET_W];
   assign c_tag = bus.tlbvaddr[31:OFFSET_W+INDEX_W];

   // Write-port controls shared by all ways
   logic [WAYS-1:0]    v_we, v_wdata, f_we;
   logic [INDEX_W-1:0] v_addr, rr_addr;
   logic               rr_we;
   logic [WAY_W-1:0]   rr_wdata;

   // Per-way read results
   logic [WAYS-1:0]                 c_valid, c_hit, f_g, lk_hit, lk_w;
   logic [WAYS-1:0][ASID_WIDTH-1:0] f_asid;
   logic [WAYS-1:0][PFN_W-1:0]      lk_pfn;

   // Lookup reads are registered; maintenance paths (update way choice, ASID
   // flush) need same-cycle reads of a different set, so they read combinationally.
   genvar gi;
   generate
      for (gi = 0; gi < WAYS; gi++) begin : g_way
         logic                  valid_mem [ENTRIES];
         logic                  g_mem     [ENTRIES];
         logic                  w_mem     [ENTRIES];
         logic [ASID_WIDTH-1:0] asid_mem  [ENTRIES];
         logic [TAG_W-1:0]      tag_mem   [ENTRIES];
         logic [PFN_W-1:0]      pfn_mem   [ENTRIES];

         logic                  lk_valid_q, lk_g_q, lk_w_q;
         logic [ASID_WIDTH-1:0] lk_asid_q;
         logic [TAG_W-1:0]      lk_tag_q;
         logic [PFN_W-1:0]      lk_pfn_q;

         always_ff @(posedge clk_i) begin
            if (v_we[gi]) valid_mem[v_addr] <= v_wdata[gi];
            if (f_we[gi]) begin
               g_mem[c_idx]    <= bus.tlbflags[1];
               w_mem[c_idx]    <= bus.tlbflags[0];
               asid_mem[c_idx] <= bus.asid;
               tag_mem[c_idx]  <= c_tag;
               pfn_mem[c_idx]  <= bus.tlbpaddr[31:OFFSET_W];
            end
            lk_valid_q <= valid_mem[x_idx];
            lk_g_q     <= g_mem[x_idx];
            lk_w_q     <= w_mem[x_idx];
            lk_asid_q  <= asid_mem[x_idx];
            lk_tag_q   <= tag_mem[x_idx];
            lk_pfn_q   <= pfn_mem[x_idx];
         end

         assign c_valid[gi] = valid_mem[c_idx];
         assign c_hit[gi]   = valid_mem[c_idx] && (tag_mem[c_idx] == c_tag)
                              && (g_mem[c_idx] || (asid_mem[c_idx] == bus.asid));
         assign f_g[gi]     = g_mem[flush_set_q];
         assign f_asid[gi]  = asid_mem[flush_set_q];
         assign lk_hit[gi]  = lk_valid_q && (lk_tag_q == x_tag)
                              && (lk_g_q || (lk_asid_q == bus.asid));
         assign lk_w[gi]    = lk_w_q;
         assign lk_pfn[gi]  = lk_pfn_q;
      end
   endgenerate

   logic [WAY_W-1:0] rr_mem [ENTRIES];
   logic [WAY_W-1:0] rr_rd, rr_next;

   always_ff @(posedge clk_i) begin
      if (rr_we) rr_mem[rr_addr] <= rr_wdata;
   end

   assign rr_rd   = rr_mem[c_idx];
   assign rr_next = (rr_rd == WAY_W'(WAYS - 1)) ? '0 : rr_rd + 1'b1;

   // Update victim: hitting way, else lowest invalid way, else round-robin
   logic [WAY_W-1:0] upd_way;
   logic             upd_use_rr;
   logic [WAYS-1:0]  upd_oh;

   always_comb begin
      upd_way    = rr_rd;
      upd_use_rr = 1'b1;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!c_valid[w]) begin
            upd_way    = WAY_W'(w);
            upd_use_rr = 1'b0;
         end
      end
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (c_hit[w]) begin
            upd_way    = WAY_W'(w);
            upd_use_rr = 1'b0;
         end
      end
      for (int w = 0; w < WAYS; w++) upd_oh[w] = (upd_way == WAY_W'(w));
   end

   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      flush_set_d  = flush_set_q;
      flush_asid_d = flush_asid_q;
      v_we         = '0;
      v_wdata      = '0;
      v_addr       = c_idx;
      f_we         = '0;
      rr_we        = 1'b0;
      rr_wdata     = '0;
      rr_addr      = c_idx;
      case (state_q)
         CHECK: begin
            if (bus.invalidate) begin
               v_we = c_hit;
            end else if (bus.update) begin
               v_we    = upd_oh;
               v_wdata = '1;
               f_we    = upd_oh;
               if (upd_use_rr) begin
                  rr_we    = 1'b1;
                  rr_wdata = rr_next;
               end
            end
            if (bus.flush || bus.flush_asid) begin
               state_d      = FLUSH;
               flush_set_d  = LAST_SET;
               mode_d       = bus.flush ? MODE_ALL : MODE_ASID;
               flush_asid_d = bus.asid;
            end
         end
         FLUSH: begin
            v_addr  = flush_set_q;
            rr_addr = flush_set_q;
            for (int w = 0; w < WAYS; w++) begin
               v_we[w] = (mode_q == MODE_ALL) || (!f_g[w] && (f_asid[w] == flush_asid_q));
            end
            rr_we = (mode_q == MODE_ALL);
            if (bus.flush || bus.flush_asid) begin
               flush_set_d  = LAST_SET;
               mode_d       = (bus.flush || (mode_q == MODE_ALL)) ? MODE_ALL : MODE_ASID;
               flush_asid_d = bus.asid;
            end else if (flush_set_q == '0) begin
               state_d = CHECK;
            end else begin
               flush_set_d = flush_set_q - 1'b1;
            end
         end
         default: state_d = FLUSH;
      endcase
      if (rst_i) begin
         v_we  = '0;
         f_we  = '0;
         rr_we = 1'b0;
      end
   end

   logic             hit, sel_w;
   logic [PFN_W-1:0] sel_pfn;

   always_comb begin
      hit     = |lk_hit;
      sel_w   = 1'b0;
      sel_pfn = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (lk_hit[w]) begin
            sel_w   = lk_w[w];
            sel_pfn = lk_pfn[w];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= FLUSH;
         mode_q       <= MODE_ALL;
         flush_set_q  <= LAST_SET;
         flush_asid_q <= '0;
         lookup_q     <= 1'b0;
         pfn_m_q      <= '0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         flush_set_q  <= flush_set_d;
         flush_asid_q <= flush_asid_d;
         lookup_q     <= bus.enable && !bus.stall_x && (bus.load_d || bus.store_d);
         if (!bus.stall_m) pfn_m_q <= sel_pfn;
      end
   end

   assign bus.miss  = !rst_i && bus.enable && (bus.load_q_x || bus.store_q_x)
                      && !lookup_q && !hit;
   assign bus.fault = !rst_i && bus.enable && bus.store_q_x && !lookup_q && hit && !sel_w;
   assign bus.stall_request = lookup_q || (state_q == FLUSH);
   assign bus.physical_load_store_address_m =
      bus.enable ? {pfn_m_q, bus.address_m[OFFSET_W-1:0]} : bus.address_m;

   logic unused_bits;
   assign unused_bits = ^{bus.tlbvaddr[OFFSET_W-1:0], bus.tlbpaddr[OFFSET_W-1:0],
                          bus.address_x[OFFSET_W-1:0]};
endmodule

// File: tb/tb_lm32_dtlb_assoc.sv
// Directed bench for lm32_dtlb_assoc (1024 sets, 2 ways, 4 KiB pages):
// reset flush, hit/miss, ASID isolation, write faults, replacement and flushes.
module tb_lm32_dtlb_assoc;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   lm32_dtlb_assoc_if #(.ASID_WIDTH(8)) bus ();

   lm32_dtlb_assoc #(
      .ENTRIES(1024), .WAYS(2), .PAGE_SIZE(4096), .ASID_WIDTH(8)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end else begin
         $display("ok   %s = %08h", tag, got);
      end
   endtask

   // Walks one access through D, X (lookup), X (result) and M
   task automatic access(input logic [31:0] addr, input logic st, input logic [7:0] asid_v,
                         output logic m, output logic f, output logic [31:0] pa);
      @(negedge clk);
      bus.asid      = asid_v;
      bus.stall_x   = 1'b0;
      bus.load_d    = !st;
      bus.store_d   = st;
      bus.address_x = addr;
      @(negedge clk);
      check("lookup_stall", 32'(bus.stall_request), 32'd1);
      bus.load_d    = 1'b0;
      bus.store_d   = 1'b0;
      bus.load_q_x  = !st;
      bus.store_q_x = st;
      bus.stall_x   = 1'b1;
      @(negedge clk);
      m = bus.miss;
      f = bus.fault;
      bus.stall_x   = 1'b0;
      @(negedge clk);
      bus.load_q_x  = 1'b0;
      bus.store_q_x = 1'b0;
      bus.address_m = addr;
      #1;
      pa = bus.physical_load_store_address_m;
      $display("%s %08h asid=%0d miss=%0b fault=%0b pa=%08h",
               st ? "store" : "load ", addr, asid_v, m, f, pa);
   endtask

   task automatic cmd(input logic [31:0] va, input logic [31:0] pa, input logic [1:0] flags,
                      input logic [7:0] asid_v, input logic upd, input logic inv);
      @(negedge clk);
      bus.asid       = asid_v;
      bus.tlbvaddr   = va;
      bus.tlbpaddr   = pa;
      bus.tlbflags   = flags;
      bus.update     = upd;
      bus.invalidate = inv;
      @(negedge clk);
      bus.update     = 1'b0;
      bus.invalidate = 1'b0;
      $display("cmd va=%08h pa=%08h flags=%02b asid=%0d upd=%0b inv=%0b",
               va, pa, flags, asid_v, upd, inv);
   endtask

   task automatic count_stall(output int n);
      n = 0;
      while (bus.stall_request && n < 3000) begin
         n++;
         @(negedge clk);
      end
   endtask

   logic        m, f;
   logic [31:0] pa;
   int          n;

   initial begin
      bus.enable = 1'b0;  bus.stall_x = 1'b0;  bus.stall_m = 1'b0;
      bus.address_x = '0; bus.address_m = 32'hDEAD_BEEF;
      bus.load_d = 1'b0;  bus.store_d = 1'b0;  bus.load_q_x = 1'b0; bus.store_q_x = 1'b0;
      bus.asid = '0;      bus.tlbvaddr = '0;   bus.tlbpaddr = '0;   bus.tlbflags = '0;
      bus.update = 1'b0;  bus.invalidate = 1'b0; bus.flush = 1'b0;  bus.flush_asid = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_stall", 32'(bus.stall_request), 32'd1);
      check("rst_pa_noen", bus.physical_load_store_address_m, 32'hDEAD_BEEF);
      bus.enable   = 1'b1;
      bus.load_q_x = 1'b1;
      #1;
      check("rst_miss", 32'(bus.miss), 32'd0);
      check("rst_pa_en", bus.physical_load_store_address_m, 32'h0000_0EEF);
      bus.load_q_x = 1'b0;

      @(negedge clk);
      rst = 1'b0;
      count_stall(n);
      check("reset_flush_len", 32'(n), 32'd1024);

      access(32'h0000_1000, 1'b0, 8'd0, m, f, pa);
      check("empty_miss", 32'(m), 32'd1);

      cmd(32'h1234_5000, 32'h0ABC_D000, 2'b01, 8'd3, 1'b1, 1'b0);
      access(32'h1234_5678, 1'b0, 8'd3, m, f, pa);
      check("hit_miss", 32'(m), 32'd0);
      check("hit_fault", 32'(f), 32'd0);
      check("hit_pa", pa, 32'h0ABC_D678);

      access(32'h1234_5678, 1'b0, 8'd4, m, f, pa);
      check("asid4_miss", 32'(m), 32'd1);

      cmd(32'h1234_5000, 32'h0ABC_D000, 2'b11, 8'd3, 1'b1, 1'b0);
      access(32'h1234_5678, 1'b0, 8'd4, m, f, pa);
      check("global_miss", 32'(m), 32'd0);
      check("global_pa", pa, 32'h0ABC_D678);

      cmd(32'h1234_5000, 32'h0ABC_D000, 2'b00, 8'd3, 1'b1, 1'b0);
      access(32'h1234_5010, 1'b1, 8'd3, m, f, pa);
      check("ro_store_fault", 32'(f), 32'd1);
      check("ro_store_miss", 32'(m), 32'd0);
      access(32'h1234_5010, 1'b0, 8'd3, m, f, pa);
      check("ro_load_fault", 32'(f), 32'd0);
      check("ro_load_miss", 32'(m), 32'd0);

      // Three pages in set 1: the third evicts way 0 via the round-robin pointer
      cmd(32'h0000_1000, 32'h0011_1000, 2'b01, 8'd3, 1'b1, 1'b0);
      cmd(32'h0040_1000, 32'h0022_1000, 2'b01, 8'd3, 1'b1, 1'b0);
      cmd(32'h0080_1000, 32'h0033_1000, 2'b01, 8'd3, 1'b1, 1'b0);
      access(32'h0000_1000, 1'b0, 8'd3, m, f, pa);
      check("evicted_miss", 32'(m), 32'd1);
      access(32'h0040_1234, 1'b0, 8'd3, m, f, pa);
      check("kept1_miss", 32'(m), 32'd0);
      check("kept1_pa", pa, 32'h0022_1234);
      access(32'h0080_1ABC, 1'b0, 8'd3, m, f, pa);
      check("kept2_miss", 32'(m), 32'd0);
      check("kept2_pa", pa, 32'h0033_1ABC);

      cmd(32'h0100_2000, 32'h0044_2000, 2'b11, 8'd3, 1'b1, 1'b0);
      cmd(32'h0140_2000, 32'h0055_2000, 2'b01, 8'd5, 1'b1, 1'b0);

      @(negedge clk);
      bus.asid       = 8'd3;
      bus.flush_asid = 1'b1;
      @(negedge clk);
      bus.flush_asid = 1'b0;
      count_stall(n);
      check("asid_flush_len", 32'(n), 32'd1024);
      access(32'h0040_1000, 1'b0, 8'd3, m, f, pa);
      check("af_asid3_a", 32'(m), 32'd1);
      access(32'h0080_1000, 1'b0, 8'd3, m, f, pa);
      check("af_asid3_b", 32'(m), 32'd1);
      access(32'h1234_5010, 1'b0, 8'd3, m, f, pa);
      check("af_asid3_c", 32'(m), 32'd1);
      access(32'h0100_2040, 1'b0, 8'd3, m, f, pa);
      check("af_global_miss", 32'(m), 32'd0);
      check("af_global_pa", pa, 32'h0044_2040);
      access(32'h0140_2008, 1'b0, 8'd5, m, f, pa);
      check("af_asid5_miss", 32'(m), 32'd0);
      check("af_asid5_pa", pa, 32'h0055_2008);

      cmd(32'h0140_2000, 32'h0066_2000, 2'b01, 8'd5, 1'b1, 1'b1);
      access(32'h0140_2008, 1'b0, 8'd5, m, f, pa);
      check("updinv_existing", 32'(m), 32'd1);
      cmd(32'h0180_3000, 32'h0077_3000, 2'b01, 8'd5, 1'b1, 1'b1);
      access(32'h0180_3000, 1'b0, 8'd5, m, f, pa);
      check("updinv_fresh", 32'(m), 32'd1);
      cmd(32'h0180_3000, 32'h0077_3000, 2'b01, 8'd5, 1'b1, 1'b0);
      access(32'h0180_3004, 1'b0, 8'd5, m, f, pa);
      check("upd_after_miss", 32'(m), 32'd0);
      check("upd_after_pa", pa, 32'h0077_3004);

      @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      count_stall(n);
      check("full_flush_len", 32'(n), 32'd1024);
      access(32'h0100_2040, 1'b0, 8'd3, m, f, pa);
      check("ff_global_miss", 32'(m), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
